// File: rtl/pll_video_cfg_pkg.sv
// Shared definitions for the video PLL reconfiguration sequencer:
// register map, FSM states and the per-mode PLL settings table.
package pll_video_cfg_pkg;

  localparam logic [5:0] ADDR_MODE  = 6'd0;
  localparam logic [5:0] ADDR_START = 6'd2;
  localparam logic [5:0] ADDR_N     = 6'd3;
  localparam logic [5:0] ADDR_M     = 6'd4;
  localparam logic [5:0] ADDR_C0    = 6'd5;
  localparam logic [5:0] ADDR_K     = 6'd7;
  localparam logic [5:0] ADDR_BW    = 6'd8;
  localparam logic [5:0] ADDR_CP    = 6'd9;

  localparam int NUM_WRITES = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_SETTLE,
    ST_WAIT_LOCK,
    ST_FAIL
  } state_t;

  typedef struct packed {
    logic [31:0] n;
    logic [31:0] m;
    logic [31:0] c0;
    logic [31:0] k;
    logic [31:0] bw;
    logic [31:0] cp;
  } mode_cfg_t;

  // Entry 0: NTSC 63.055910 MHz, entry 1: PAL.
  localparam mode_cfg_t MODE_TABLE [0:1] = '{
    '{n: 32'h0001_0000, m: 32'h0002_0605, c0: 32'h0002_0504,
      k: 32'h599D_C7FD, bw: 32'd6, cp: 32'd2},
    '{n: 32'h0001_0000, m: 32'h0002_0606, c0: 32'h0002_0505,
      k: 32'h2E14_7AE1, bw: 32'd7, cp: 32'd2}
  };

endpackage

// File: rtl/pll_video_cfg.sv
// Video PLL reprogramming sequencer: writes the mode's settings through the
// reconfig management port, waits to settle, then waits for lock.
// Optional lock timeout is built when PLL_VIDEO_CFG_TIMEOUT_EN is defined.
module pll_video_cfg
  import pll_video_cfg_pkg::*;
#(
  parameter int SETTLE_CYCLES = 16,
  parameter int LOCK_TIMEOUT  = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        mode_sel,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [5:0]  mgmt_address,
  output logic        mgmt_write,
  output logic [31:0] mgmt_writedata,
  input  logic        mgmt_waitrequest,
  input  logic        pll_locked
);

  if (SETTLE_CYCLES < 1 || LOCK_TIMEOUT < 1) begin : g_bad_param
    $error("pll_video_cfg: SETTLE_CYCLES and LOCK_TIMEOUT must be at least 1");
  end

  localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYCLES - 1);

  state_t      state;
  logic [2:0]  idx;
  logic [31:0] settle_cnt;
  logic        mode;
  mode_cfg_t   cfg;
  logic        lock_seen;
  logic        last_write_done;
  logic        tmo_hit;

  assign cfg             = MODE_TABLE[mode];
  assign lock_seen       = (state == ST_WAIT_LOCK) && pll_locked;
  assign last_write_done = (state == ST_WRITE) && !mgmt_waitrequest && (idx == 3'd7);

  // Lock is reported in the same cycle it is seen, so busy drops with done.
  assign done       = lock_seen;
  assign busy       = ((state == ST_WRITE) || (state == ST_SETTLE) ||
                       (state == ST_WAIT_LOCK)) && !lock_seen;
  assign mgmt_write = (state == ST_WRITE);

  always_comb begin
    mgmt_address   = '0;
    mgmt_writedata = '0;
    if (state == ST_WRITE) begin
      case (idx)
        3'd0:    begin mgmt_address = ADDR_MODE;  mgmt_writedata = 32'd0;  end
        3'd1:    begin mgmt_address = ADDR_N;     mgmt_writedata = cfg.n;  end
        3'd2:    begin mgmt_address = ADDR_M;     mgmt_writedata = cfg.m;  end
        3'd3:    begin mgmt_address = ADDR_C0;    mgmt_writedata = cfg.c0; end
        3'd4:    begin mgmt_address = ADDR_K;     mgmt_writedata = cfg.k;  end
        3'd5:    begin mgmt_address = ADDR_BW;    mgmt_writedata = cfg.bw; end
        3'd6:    begin mgmt_address = ADDR_CP;    mgmt_writedata = cfg.cp; end
        default: begin mgmt_address = ADDR_START; mgmt_writedata = 32'd1;  end
      endcase
    end
  end

`ifdef PLL_VIDEO_CFG_TIMEOUT_EN
  localparam logic [31:0] TMO_LAST = 32'(LOCK_TIMEOUT - 1);

  logic [31:0] tmo_cnt;
  logic        error_q;

  assign tmo_hit = (tmo_cnt == TMO_LAST) &&
                   ((state == ST_SETTLE) || ((state == ST_WAIT_LOCK) && !pll_locked));
  assign error   = error_q;

  // Timeout window opens on SETTLE entry and spans SETTLE plus WAIT_LOCK.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= '0;
      error_q <= 1'b0;
    end else begin
      if (last_write_done) tmo_cnt <= '0;
      else if ((state == ST_SETTLE) || (state == ST_WAIT_LOCK)) tmo_cnt <= tmo_cnt + 32'd1;
      else tmo_cnt <= '0;

      if (tmo_hit) error_q <= 1'b1;
      else if ((state == ST_IDLE) && req) error_q <= 1'b0;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign error   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      idx        <= '0;
      settle_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            mode  <= mode_sel;
            idx   <= '0;
            state <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (!mgmt_waitrequest) begin
            if (idx == 3'd7) begin
              idx        <= '0;
              settle_cnt <= '0;
              state      <= ST_SETTLE;
            end else begin
              idx <= idx + 3'd1;
            end
          end
        end
        ST_SETTLE: begin
          if (tmo_hit) begin
            settle_cnt <= '0;
            state      <= ST_FAIL;
          end else if (settle_cnt == SETTLE_LAST) begin
            settle_cnt <= '0;
            state      <= ST_WAIT_LOCK;
          end else begin
            settle_cnt <= settle_cnt + 32'd1;
          end
        end
        ST_WAIT_LOCK: begin
          if (pll_locked) state <= ST_IDLE;
          else if (tmo_hit) state <= ST_FAIL;
        end
        ST_FAIL: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/pll_video_cfg.md
PLL_VIDEO_CFG -- requirements
Module: pll_video_cfg

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 16: wait after START write before lock is sampled.
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 1000000: clk cycles allowed for lock (only used when the timeout feature is built in).
REQ-003 SHALL have port clk, input, 1: single clock, also the PLL reconfig management clock.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port req, input, 1: one-cycle request to reprogram the PLL.
REQ-006 SHALL have port mode_sel, input, 1: video mode index (0 = NTSC 63.055910 MHz, 1 = PAL), sampled with req.
REQ-007 SHALL have port busy, output, 1: sequence in progress.
REQ-008 SHALL have port done, output, 1: one-cycle pulse when the PLL has relocked.
REQ-009 SHALL have port error, output, 1: sticky lock-timeout flag.
REQ-010 SHALL have port mgmt_address, output, 6: reconfig register address.
REQ-011 SHALL have port mgmt_write, output, 1: write strobe.
REQ-012 SHALL have port mgmt_writedata, output, 32: write data.
REQ-013 SHALL have port mgmt_waitrequest, input, 1: reconfig IP stall.
REQ-014 SHALL have port pll_locked, input, 1: PLL locked, already synchronous to clk.

Function
REQ-015 States SHALL be IDLE, WRITE, SETTLE, WAIT_LOCK, FAIL.
REQ-016 In IDLE, req=1 SHALL latch mode_sel, set busy and enter WRITE with write index 0 on the next cycle.
REQ-017 WRITE SHALL issue 8 writes in fixed order, as (address, data):
- (0, 0) waitrequest mode
- (3, N)
- (4, M)
- (5, C0)
- (7, K)
- (8, BW)
- (9, CP)
- (2, 1) START
REQ-018 Each write SHALL hold mgmt_write, address and data stable until a clk edge with mgmt_waitrequest=0; that edge completes the write and advances the index.
REQ-019 With waitrequest low throughout, mgmt_write SHALL be high for exactly 8 consecutive cycles.
REQ-020 Mode 0 table values SHALL be N=0x00010000, M=0x00020605, C0=0x00020504, K=0x599DC7FD, BW=6, CP=2.
REQ-021 Mode 1 table values SHALL be defined in the package.
REQ-022 After the START write completes, the block SHALL enter SETTLE for SETTLE_CYCLES cycles, then WAIT_LOCK.
REQ-023 In WAIT_LOCK, pll_locked=1 SHALL pulse done for one cycle, clear busy and return to IDLE in that same cycle.
REQ-024 req while busy SHALL be ignored: no queuing, latched mode unchanged.
REQ-025 mode_sel changes while busy SHALL have no effect.
REQ-026 Outside WRITE, mgmt_write SHALL be 0 and mgmt_address/mgmt_writedata SHALL be 0.
REQ-027 A new req SHALL clear error.

Reset
REQ-028 rst SHALL force IDLE with busy=0, done=0, error=0, mgmt_write=0, mgmt_address=0, mgmt_writedata=0 and all counters at 0, taking effect on the next clk edge.
REQ-029 rst mid-sequence SHALL abandon the sequence, deassert mgmt_write on the next edge and leave the PLL untouched until the next req.

Configuration
REQ-030 With PLL_VIDEO_CFG_TIMEOUT_EN defined, a counter SHALL run from SETTLE entry. Reaching LOCK_TIMEOUT before lock SHALL set error, clear busy, pulse no done and return to IDLE via FAIL (one cycle).
REQ-031 Without PLL_VIDEO_CFG_TIMEOUT_EN, WAIT_LOCK SHALL wait indefinitely, error SHALL be constant 0 and the counter SHALL not be built.

Structure
REQ-032 Package pll_video_cfg_pkg SHALL hold the register address constants, the state enum, the per-mode record type (N, M, C0, K, BW, CP) and the 2-entry mode table.
REQ-033 Write-index-to-address/data selection SHALL be combinational within the module; no sub-module is required.

Verification
REQ-034 Mode 0, waitrequest always low, pll_locked high -> 8 writes on consecutive cycles with the exact REQ-017/REQ-020 values, then done exactly SETTLE_CYCLES+1 cycles after the START write.
REQ-035 waitrequest held high 5 cycles during the M write -> M write held stable 6 cycles, no write skipped or duplicated, total 13 write cycles.
REQ-036 req and mode_sel=1 asserted mid-sequence of a mode-0 run -> ignored, mode-0 data completes, single done.
REQ-037 pll_locked low with TIMEOUT_EN and LOCK_TIMEOUT=100 -> error=1 and busy=0 after 100 cycles from SETTLE entry, no done; the next req clears error.
REQ-038 rst asserted during the K write -> mgmt_write=0 next cycle, all outputs at reset values; a fresh req restarts from the (0, 0) write.
